float_mult_pipe: RTL

FLOAT_MULT_PIPE -- requirements
Module: float_mult_pipe

---
 rtl/float_mult_pipe.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/float_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// Subnormal inputs flush to zero; results are RNE or RTZ rounded.
module float_mult_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   iRst,
  input  logic                   iInValid,
  output logic                   oInReady,
  input  logic [EXP_W+MAN_W:0]   iNum1,
  input  logic [EXP_W+MAN_W:0]   iNum2,
  input  logic                   iRnd,
  output logic                   oOutValid,
  input  logic                   iOutReady,
  output logic [EXP_W+MAN_W:0]   oNum,
  output logic [3:0]             oFlags
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned SigW   = MAN_W + 1;
  localparam int unsigned ProdW  = 2 * SigW;
  localparam int unsigned RndW   = SigW + 1;
  localparam int unsigned XW     = EXP_W + 2;
  localparam int unsigned Bias   = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned ExpMax = (1 << EXP_W) - 1;
  localparam logic signed [XW-1:0] ExpMaxS = XW'(ExpMax);

  typedef enum logic [1:0] {ClsNum, ClsZero, ClsInf, ClsNan} cls_e;

  // Handshake: a stage advances when the stage after it is empty or advancing
  logic v1_q, v2_q, v3_q;
  logic rdy1, rdy2, rdy3;

  assign rdy3      = !v3_q || iOutReady;
  assign rdy2      = !v2_q || rdy3;
  assign rdy1      = !v1_q || rdy2;
  assign oInReady  = rdy1 && !iRst;
  assign oOutValid = v3_q;

  always_ff @(posedge clk) begin
    if (iRst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (rdy1) v1_q <= iInValid;
      if (rdy2) v2_q <= v1_q;
      if (rdy3) v3_q <= v2_q;
    end
  end

  // ---------------- Stage 1: unpack, classify, exponent add, multiply
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] f1, f2;
  logic             nan1, nan2, inf1, inf2, zero1, zero2;
  cls_e             cls_d;
  logic             inv_d;
  logic signed [XW-1:0] exp_sum_d;
  logic [ProdW-1:0] prod_d;

  assign e1    = iNum1[W-2 -: EXP_W];
  assign e2    = iNum2[W-2 -: EXP_W];
  assign f1    = iNum1[MAN_W-1:0];
  assign f2    = iNum2[MAN_W-1:0];
  assign nan1  = (&e1) && (|f1);
  assign nan2  = (&e2) && (|f2);
  assign inf1  = (&e1) && !(|f1);
  assign inf2  = (&e2) && !(|f2);
  // Exponent zero covers both true zero and flushed subnormals
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);

  always_comb begin
    cls_d = ClsNum;
    inv_d = 1'b0;
    if (nan1 || nan2) begin
      cls_d = ClsNan;
    end else if ((inf1 && zero2) || (zero1 && inf2)) begin
      cls_d = ClsNan;
      inv_d = 1'b1;
    end else if (inf1 || inf2) begin
      cls_d = ClsInf;
    end else if (zero1 || zero2) begin
      cls_d = ClsZero;
    end
  end

  assign exp_sum_d = XW'(e1) + XW'(e2) - XW'(Bias);
  assign prod_d    = ProdW'({1'b1, f1}) * ProdW'({1'b1, f2});

  cls_e                 cls_q;
  logic                 inv_q, sign1_q, rnd_q;
  logic signed [XW-1:0] exp1_q;
  logic [ProdW-1:0]     prod_q;

  always_ff @(posedge clk) begin
    if (iInValid && oInReady) begin
      cls_q   <= cls_d;
      inv_q   <= inv_d;
      sign1_q <= iNum1[W-1] ^ iNum2[W-1];
      rnd_q   <= iRnd;
      exp1_q  <= exp_sum_d;
      prod_q  <= prod_d;
    end
  end

  // ---------------- Stage 2: normalise and round
  logic [ProdW-1:0]     prod_n;
  logic signed [XW-1:0] exp_n, exp_r;
  logic [SigW-1:0]      sig;
  logic                 guard, sticky, inc, carry, inexact;
  logic [RndW-1:0]      sig_r;
  logic [MAN_W-1:0]     frac_r;
  logic                 sign2_d;
  logic [EXP_W-1:0]     exp2_d;
  logic [MAN_W-1:0]     frac2_d;
  logic [3:0]           flags2_d;

  always_comb begin
    prod_n  = prod_q[ProdW-1] ? prod_q : (prod_q << 1);
    exp_n   = exp1_q + XW'(prod_q[ProdW-1]);
    sig     = prod_n[ProdW-1 -: SigW];
    guard   = prod_n[MAN_W];
    sticky  = |prod_n[MAN_W-1:0];
    inexact = guard || sticky;
    inc     = !rnd_q && guard && (sticky || sig[0]);
    sig_r   = {1'b0, sig} + RndW'(inc);
    carry   = sig_r[SigW];
    // A carry-out leaves the significand at exactly 1.0
    frac_r  = carry ? '0 : sig_r[MAN_W-1:0];
    exp_r   = exp_n + XW'(carry);

    sign2_d  = sign1_q;
    exp2_d   = '0;
    frac2_d  = '0;
    flags2_d = '0;
    unique case (cls_q)
      ClsNan: begin
        sign2_d          = 1'b0;
        exp2_d           = '1;
        frac2_d[MAN_W-1] = 1'b1;
        flags2_d         = {inv_q, 3'b000};
      end
      ClsInf: begin
        exp2_d = '1;
      end
      ClsZero: begin
        exp2_d = '0;
      end
      default: begin
        if (exp_n[XW-1] || (exp_n == '0)) begin
          flags2_d = 4'b0011;
        end else if (exp_r >= ExpMaxS) begin
          flags2_d = 4'b0101;
          if (rnd_q) begin
            exp2_d  = EXP_W'(ExpMax - 1);
            frac2_d = '1;
          end else begin
            exp2_d = '1;
          end
        end else begin
          exp2_d   = exp_r[EXP_W-1:0];
          frac2_d  = frac_r;
          flags2_d = {3'b000, inexact};
        end
      end
    endcase
  end

  logic             sign2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [MAN_W-1:0] frac2_q;
  logic [3:0]       flags2_q;

  always_ff @(posedge clk) begin
    if (v1_q && rdy2) begin
      sign2_q  <= sign2_d;
      exp2_q   <= exp2_d;
      frac2_q  <= frac2_d;
      flags2_q <= flags2_d;
    end
  end

  // ---------------- Stage 3: pack and register outputs
  logic [W-1:0] num3_q;
  logic [3:0]   flags3_q;

  always_ff @(posedge clk) begin
    if (iRst) begin
      num3_q   <= '0;
      flags3_q <= '0;
    end else if (v2_q && rdy3) begin
      num3_q   <= {sign2_q, exp2_q, frac2_q};
      flags3_q <= flags2_q;
    end
  end

  assign oNum   = num3_q;
  assign oFlags = flags3_q;

endmodule
